// File: rtl/gp_addr_dec_pkg.sv
// Shared types and default region map for the gp_engine AHB region decoder.
package gp_addr_dec_pkg;

  localparam int unsigned MAX_REGIONS = 8;
  localparam int unsigned BASE_WIDTH  = 30;
  localparam int unsigned SIZE_WIDTH  = 32;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    ERR1,
    ERR2
  } dec_state_t;

  typedef logic [MAX_REGIONS-1:0][BASE_WIDTH-1:0] base_arr_t;
  typedef logic [MAX_REGIONS-1:0][SIZE_WIDTH-1:0] size_arr_t;

  // Register File sits at word 0, the Command Buffer directly above it.
  localparam logic [BASE_WIDTH-1:0] RF_BASE = 30'h0;
  localparam logic [SIZE_WIDTH-1:0] RF_SIZE = 32'd4;
  localparam logic [BASE_WIDTH-1:0] CB_BASE = 30'h4;
  localparam logic [SIZE_WIDTH-1:0] CB_SIZE = 32'd256;

  localparam base_arr_t DEFAULT_REGION_BASE =
    {{(MAX_REGIONS-2){{BASE_WIDTH{1'b0}}}}, CB_BASE, RF_BASE};
  localparam size_arr_t DEFAULT_REGION_SIZE =
    {{(MAX_REGIONS-2){{SIZE_WIDTH{1'b0}}}}, CB_SIZE, RF_SIZE};

  function automatic logic is_err_state(dec_state_t s);
    return (s == ERR1) || (s == ERR2);
  endfunction

endpackage

// File: rtl/gp_region_decoder_if.sv
// AHB-side address phase and response signals of the gp_engine region decoder.
interface gp_region_decoder_if #(
  parameter int unsigned ADDR_WIDTH = 32
);

  logic [ADDR_WIDTH-1:0] slv_o_addr;
  logic                  slv_o_valid;
  logic                  slv_o_write;
  logic                  slv_i_ready;
  logic                  slv_i_err;

  modport master (
    output slv_o_addr,
    output slv_o_valid,
    output slv_o_write,
    input  slv_i_ready,
    input  slv_i_err
  );

  modport slave (
    input  slv_o_addr,
    input  slv_o_valid,
    input  slv_o_write,
    output slv_i_ready,
    output slv_i_err
  );

endinterface

// File: rtl/gp_region_decoder_match.sv
// gp_region_match: combinational hit test and word offset for a single region.
module gp_region_match #(
  parameter int unsigned WORD_WIDTH = 30,
  parameter int unsigned OFF_WIDTH  = 8
) (
  input  logic [WORD_WIDTH-1:0] word_i,
  input  logic [WORD_WIDTH-1:0] base_i,
  input  logic [31:0]           size_i,
  output logic                  hit_o,
  output logic [OFF_WIDTH-1:0]  offset_o
);

  localparam int unsigned CW = ((WORD_WIDTH > 32) ? WORD_WIDTH : 32) + 1;

  logic [WORD_WIDTH-1:0] delta;
  logic [CW-1:0]         deltaExt;
  logic [CW-1:0]         sizeExt;

  // Comparing the distance from base against size avoids ever forming base+size,
  // which could wrap at the top of the address space.
  assign delta    = word_i - base_i;
  assign deltaExt = CW'(delta);
  assign sizeExt  = CW'(size_i);

  assign hit_o    = (size_i != '0) && (word_i >= base_i) && (deltaExt < sizeExt);
  assign offset_o = delta[OFF_WIDTH-1:0];

endmodule

// File: rtl/gp_region_decoder.sv
// gp_region_decoder: registered AHB slave address decoder with up to 8 regions.
// Define GP_DECODER_ERR_CNT_EN to add a saturating unmapped-access counter.
module gp_region_decoder
  import gp_addr_dec_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH       = 32,
  parameter int unsigned TRANS_ADDR_WIDTH = 8,
  parameter int unsigned NUM_REGIONS      = 2,
  parameter base_arr_t   REGION_BASE      = DEFAULT_REGION_BASE,
  parameter size_arr_t   REGION_SIZE      = DEFAULT_REGION_SIZE
) (
  input  logic                        clk,
  input  logic                        rst,
  gp_region_decoder_if.slave          slv,
`ifdef GP_DECODER_ERR_CNT_EN
  input  logic                        err_count_clr,
  output logic [7:0]                  err_count,
`endif
  input  logic [NUM_REGIONS-1:0]      region_ready,
  output logic [NUM_REGIONS-1:0]      region_en,
  output logic [TRANS_ADDR_WIDTH-1:0] trans_addr,
  output logic                        trans_write
);

  localparam int unsigned WW = ADDR_WIDTH - 2;

  if ((NUM_REGIONS < 1) || (NUM_REGIONS > MAX_REGIONS)) begin : g_bad_num
    $error("gp_region_decoder: NUM_REGIONS must be 1..8");
  end
  if ((ADDR_WIDTH > 32) || (ADDR_WIDTH < TRANS_ADDR_WIDTH + 2)) begin : g_bad_aw
    $error("gp_region_decoder: ADDR_WIDTH must be TRANS_ADDR_WIDTH+2..32");
  end
  for (genvar k = 0; k < MAX_REGIONS; k++) begin : g_size_chk
    if (64'(REGION_SIZE[k]) > (64'd1 << TRANS_ADDR_WIDTH)) begin : g_bad_size
      $error("gp_region_decoder: region size exceeds translated address range");
    end
  end

  dec_state_t                  state_q, state_d;
  logic [NUM_REGIONS-1:0]      regionEn_q, regionEn_d;
  logic [TRANS_ADDR_WIDTH-1:0] transAddr_q, transAddr_d;
  logic                        transWrite_q, transWrite_d;

  logic [WW-1:0]               addrWord;
  logic                        unusedAddrLsb;
  logic [NUM_REGIONS-1:0]      hitVec;
  logic [TRANS_ADDR_WIDTH-1:0] offVec [NUM_REGIONS];
  logic [NUM_REGIONS-1:0]      selEn;
  logic [TRANS_ADDR_WIDTH-1:0] selOff;
  logic                        hitAny;
  logic                        curReady;
  logic                        accept;

  assign addrWord      = slv.slv_o_addr[ADDR_WIDTH-1:2];
  assign unusedAddrLsb = ^slv.slv_o_addr[1:0];

  for (genvar k = 0; k < NUM_REGIONS; k++) begin : g_region
    gp_region_match #(
      .WORD_WIDTH (WW),
      .OFF_WIDTH  (TRANS_ADDR_WIDTH)
    ) u_match (
      .word_i   (addrWord),
      .base_i   (REGION_BASE[k][WW-1:0]),
      .size_i   (REGION_SIZE[k]),
      .hit_o    (hitVec[k]),
      .offset_o (offVec[k])
    );
  end

  // Walk from the highest index down so the lowest-numbered hit is what remains.
  always_comb begin
    selEn  = '0;
    selOff = '0;
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (hitVec[k]) begin
        selEn    = '0;
        selEn[k] = 1'b1;
        selOff   = offVec[k];
      end
    end
  end

  assign hitAny = |selEn;

  always_comb begin
    curReady = 1'b1;
    case (state_q)
      DATA:    curReady = |(regionEn_q & region_ready);
      ERR1:    curReady = 1'b0;
      default: curReady = 1'b1;
    endcase
  end

  // ERR2 drives ready high to close the error response but never takes a new address.
  assign accept = slv.slv_o_valid && curReady && ((state_q == IDLE) || (state_q == DATA));

  always_comb begin
    state_d      = state_q;
    regionEn_d   = regionEn_q;
    transAddr_d  = transAddr_q;
    transWrite_d = transWrite_q;
    if (accept) begin
      transWrite_d = slv.slv_o_write;
      if (hitAny) begin
        state_d     = DATA;
        regionEn_d  = selEn;
        transAddr_d = selOff;
      end else begin
        state_d     = ERR1;
        regionEn_d  = '0;
        transAddr_d = '0;
      end
    end else begin
      case (state_q)
        DATA: begin
          if (curReady) begin
            state_d    = IDLE;
            regionEn_d = '0;
          end
        end
        ERR1:    state_d = ERR2;
        ERR2:    state_d = IDLE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      regionEn_q   <= '0;
      transAddr_q  <= '0;
      transWrite_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      regionEn_q   <= regionEn_d;
      transAddr_q  <= transAddr_d;
      transWrite_q <= transWrite_d;
    end
  end

  assign region_en       = regionEn_q;
  assign trans_addr      = transAddr_q;
  assign trans_write     = transWrite_q;
  assign slv.slv_i_ready = curReady;
  assign slv.slv_i_err   = is_err_state(state_q);

`ifdef GP_DECODER_ERR_CNT_EN
  logic [7:0] errCount_q;

  // ERR1 lasts exactly one cycle, so a next state of ERR1 marks each new error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      errCount_q <= '0;
    end else if (err_count_clr) begin
      errCount_q <= '0;
    end else if ((state_d == ERR1) && (errCount_q != 8'hFF)) begin
      errCount_q <= errCount_q + 8'd1;
    end
  end

  assign err_count = errCount_q;
`endif

endmodule
